// File: rtl/snes_controller_emu.sv
// rtl/snes_controller_emu.sv - SNES controller serial shift-out emulator
//
// Purpose:
//   Emulates the console-facing side of an SNES pad. While the host holds
//   snes_latch high, the 12 button levels are loaded (active-low) into a
//   16-bit shift register. Each rising edge of snes_pulse in the SHIFT
//   state then advances one bit onto snes_data. After 16 shifts the block
//   parks in DONE, drives 0, and ignores further pulses until the next latch.
//
// Configuration:
//   SNES_EMU_INPUT_SYNC_EN - when defined, snes_latch and snes_pulse pass
//   through two-flop synchronizers before edge detection (asynchronous pins).
//   When undefined, they are assumed to come from the sys_clk domain.
//
// Ports:
//   sys_clk     in   system clock
//   sys_reset   in   synchronous active-high reset
//   snes_latch  in   latch strobe, high = parallel load
//   snes_pulse  in   shift clock, rising edge = advance one bit
//   buttons     in   [11:0] pressed=1: B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R
//   snes_data   out  serial data, active-low, registered (sr[15])
//   bit_count   out  [4:0] shifts completed since latch fall, 0..16
//   frame_done  out  one-cycle pulse when the 16th shift completes

module snes_controller_emu (
   input  logic        sys_clk,
   input  logic        sys_reset,
   input  logic        snes_latch,
   input  logic        snes_pulse,
   input  logic [11:0] buttons,
   output logic        snes_data,
   output logic [4:0]  bit_count,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] sr;
   logic [15:0] sr_next;
   logic [4:0]  count_next;
   logic        done_next;

   logic        latch_cur;
   logic        pulse_cur;
   logic        latch_prev;
   logic        pulse_prev;
   logic        latch_fall;
   logic        pulse_rise;
   logic [15:0] load_word;

`ifdef SNES_EMU_INPUT_SYNC_EN
   logic [1:0] latch_sync;
   logic [1:0] pulse_sync;

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         latch_sync <= 2'b00;
         pulse_sync <= 2'b00;
      end else begin
         latch_sync <= {latch_sync[0], snes_latch};
         pulse_sync <= {pulse_sync[0], snes_pulse};
      end
   end

   assign latch_cur = latch_sync[1];
   assign pulse_cur = pulse_sync[1];
`else
   assign latch_cur = snes_latch;
   assign pulse_cur = snes_pulse;
`endif

   // Edge-detect history; cleared by reset so a pulse held high across
   // reset release does not look like a fresh rise later.
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         latch_prev <= 1'b0;
         pulse_prev <= 1'b0;
      end else begin
         latch_prev <= latch_cur;
         pulse_prev <= pulse_cur;
      end
   end

   assign latch_fall = ~latch_cur & latch_prev;
   assign pulse_rise = pulse_cur & ~pulse_prev;

   // B leaves first; the four trailing ID bits always read not-pressed.
   assign load_word = {~buttons, 4'b1111};

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state      <= IDLE;
         sr         <= 16'hFFFF;
         bit_count  <= 5'd0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         sr         <= sr_next;
         bit_count  <= count_next;
         frame_done <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      sr_next    = sr;
      count_next = bit_count;
      done_next  = 1'b0;

      // Latch level overrides everything, including a coincident pulse
      // rise and any frame in progress (which is aborted silently).
      if (latch_cur) begin
         state_next = LOAD;
         sr_next    = load_word;
         count_next = 5'd0;
      end else begin
         case (state)
            LOAD: begin
               if (latch_fall) begin
                  state_next = SHIFT;
               end
            end
            SHIFT: begin
               if (pulse_rise) begin
                  sr_next    = {sr[14:0], 1'b0};
                  count_next = bit_count + 5'd1;
                  if (bit_count == 5'd15) begin
                     state_next = DONE;
                     done_next  = 1'b1;
                  end
               end
            end
            // IDLE and DONE wait for a latch; pulses are ignored. In DONE
            // all 16 bits have shifted out, so sr is already zero.
            default: begin
               state_next = state;
            end
         endcase
      end
   end

   assign snes_data = sr[15];

endmodule

// File: tb/tb_snes_controller_emu.sv
// tb/tb_snes_controller_emu.sv - randomized self-checking bench for snes_controller_emu

module tb_snes_controller_emu;

`ifdef SNES_EMU_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_reset;
   logic        snes_latch;
   logic        snes_pulse;
   logic [11:0] buttons;
   logic        snes_data;
   logic [4:0]  bit_count;
   logic        frame_done;

   snes_controller_emu dut (
      .sys_clk    (sys_clk),
      .sys_reset  (sys_reset),
      .snes_latch (snes_latch),
      .snes_pulse (snes_pulse),
      .buttons    (buttons),
      .snes_data  (snes_data),
      .bit_count  (bit_count),
      .frame_done (frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc = cyc + 1;

   int fd_seen = 0;
   int fd_cyc  = -1;
   always @(negedge sys_clk) begin
      if (frame_done === 1'b1) begin
         fd_seen = fd_seen + 1;
         fd_cyc  = cyc;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a frame is the 16-bit word captured at the end of
   // the latch, plus how many bits the host has clocked out of it.
   bit          m_active;
   int          m_count;
   logic [15:0] m_word;
   int          m_fd;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int exp_data();
      if (!m_active) return 1;
      if (m_count >= 16) return 0;
      return int'(m_word[15 - m_count]);
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".data"}, int'(snes_data), exp_data());
      check({tag, ".count"}, int'(bit_count), m_count);
      check({tag, ".frame_done"}, fd_seen, m_fd);
   endtask

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      snes_latch = 1'b0;
      snes_pulse = 1'b0;
      sys_reset  = 1'b1;
      tick();
      tick();
      sys_reset  = 1'b0;
      m_active   = 1'b0;
      m_count    = 0;
      tick();
      tick();
      check_state("reset");
   endtask

   task automatic do_latch(input int hold, input logic [11:0] b_first,
                           input logic [11:0] b_last, input bit toggle);
      for (int i = 0; i < hold; i++) begin
         buttons    = (i < hold / 2) ? b_first : b_last;
         snes_latch = 1'b1;
         snes_pulse = toggle && (i % 2 == 1);
         tick();
      end
      if (hold >= LAT) check("latch.hold_count", int'(bit_count), 0);
      snes_latch = 1'b0;
      snes_pulse = 1'b0;
      m_word   = {~b_last, 4'hF};
      m_active = 1'b1;
      m_count  = 0;
      repeat (LAT + 1) tick();
      check_state("latch");
   endtask

   task automatic do_pulse(input int hi, input int lo, input bit rnd_btn);
      int rc;
      snes_pulse = 1'b1;
      rc = cyc;
      if (rnd_btn) buttons = 12'($urandom);
      repeat (hi) tick();
      snes_pulse = 1'b0;
      repeat (lo) tick();
      if (m_active && m_count < 16) begin
         m_count++;
         if (m_count == 16) begin
            m_fd++;
            check("pulse.fd_latency", fd_cyc - rc, LAT);
         end
      end
      check_state("pulse");
   endtask

   initial begin
      sys_reset  = 1'b1;
      snes_latch = 1'b0;
      snes_pulse = 1'b0;
      buttons    = 12'h000;
      m_active   = 1'b0;
      m_count    = 0;
      m_word     = 16'hFFFF;
      m_fd       = 0;

      // Reset, no latch, pulses ignored.
      do_reset();
      repeat (5) do_pulse(2, 2, 1'b0);

      // B and R pressed, full frame, then extra pulses in DONE.
      do_latch(4, 12'h801, 12'h801, 1'b0);
      repeat (16) do_pulse(2, 2, 1'b0);
      repeat (3) do_pulse(2, 2, 1'b0);

      // Buttons change while latch is held: live tracking.
      do_latch(4, 12'h000, 12'h400, 1'b0);
      do_pulse(2, 2, 1'b0);

      // Abort after 7 pulses with a new latch, then full frame.
      repeat (6) do_pulse(2, 2, 1'b1);
      do_latch(4, 12'hFFF, 12'hFFF, 1'b0);
      repeat (16) do_pulse(2, 2, 1'b1);

      // Reset after 9 pulses; following pulses ignored until next latch.
      do_latch(4, 12'h5A3, 12'h5A3, 1'b0);
      repeat (9) do_pulse(2, 2, 1'b0);
      do_reset();
      repeat (3) do_pulse(2, 2, 1'b0);

      // Pulses coincident with latch high are ignored.
      do_latch(6, 12'h3C6, 12'h9E1, 1'b1);
      repeat (16) do_pulse(2, 3, 1'b1);

      // Randomized mix of latches, pulses and resets.
      for (int n = 0; n < 300; n++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r < 3) begin
            do_latch(int'($urandom_range(1, 5)), 12'($urandom), 12'($urandom),
                     1'($urandom_range(0, 1)));
         end else if (r == 3) begin
            do_reset();
         end else begin
            do_pulse(int'($urandom_range(2, 3)), int'($urandom_range(2, 3)), 1'b1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/snes_controller_emu.md
SNES_CONTROLLER_EMU -- requirements
Module: snes_controller_emu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be as follows, clock and reset first:
- sys_clk  input  1  system clock (16 MHz)
- sys_reset  input  1  synchronous active-high reset
- snes_latch  input  1  latch strobe from the console/host; high = parallel load
- snes_pulse  input  1  shift clock from the host; rising edge = advance one bit
- buttons  input  12  pressed=1; bit 11..0 = B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R
- snes_data  output  1  serial data to the host; active-low (0 = pressed)
- bit_count  output  5  number of shifts completed since the last latch fall, 0..16
- frame_done  output  1  one-cycle pulse when the 16th shift completes

Function
REQ-003 The block SHALL hold a 16-bit shift register sr; snes_data SHALL equal sr[15] at all times.
- sr is a flop, so snes_data is registered.
REQ-004 The load word SHALL be {~buttons[11:0], 4'b1111}.
- First bit out is B.
- Bits 13-16 always read not-pressed.
REQ-005 Edge detection SHALL compare the (possibly synchronized) input with its one-cycle-delayed copy.
- Rise = cur & ~prev.
- Fall = ~cur & prev.
REQ-006 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-007 In any state, snes_latch level high SHALL force state LOAD.
- In LOAD: sr loads the load word every cycle, so button changes track live.
- In LOAD: bit_count = 0.
REQ-008 A latch fall SHALL move LOAD to SHIFT.
- sr retains the last loaded word.
- snes_data presents B.
REQ-009 In SHIFT, each pulse rise SHALL do the following on the next sys_clk edge:
- sr <= {sr[14:0], 1'b0}.
- bit_count increments.
REQ-010 When bit_count becomes 16, the FSM SHALL enter DONE and assert frame_done for exactly that one cycle.
REQ-011 In DONE, snes_data SHALL be 0 and pulse rises SHALL be ignored.
- bit_count stays at 16.
- Only a new latch leaves DONE.
REQ-012 In IDLE, pulse rises SHALL be ignored and snes_data SHALL stay 1.
REQ-013 A pulse rise coincident with latch high SHALL be ignored; load has priority.
REQ-014 Without synchronizers, snes_data SHALL change on the first sys_clk edge after the sampled pulse rise.
- This is 1-cycle latency, which is valid before a host pulse of 2 cycles high falls.
REQ-015 A latch asserted mid-frame (SHIFT or DONE) SHALL abort the frame with no frame_done pulse and reload per REQ-007.
REQ-016 buttons changes during SHIFT or DONE SHALL NOT affect sr.

Reset
REQ-017 While sys_reset is high at a sys_clk edge, the block SHALL set:
- state = IDLE
- sr = 16'hFFFF, so snes_data = 1
- bit_count = 0
- frame_done = 0
- edge-detect history registers = 0
REQ-018 sys_reset SHALL take precedence over all other inputs.
REQ-019 A reset mid-frame SHALL leave IDLE after release.
- No frame_done.
- A pulse rise before the next latch has no effect.

Configuration
REQ-020 The macro SNES_EMU_INPUT_SYNC_EN SHALL control input synchronization.
- Defined: snes_latch and snes_pulse each pass through a two-flop synchronizer, reset to 0, before edge detection. Pulse-to-data and latch-to-load latency each grow by 2 cycles (3 total). This build is for external asynchronous pins.
- Undefined: inputs feed edge detection directly, with 1-cycle latency. This build is for a same-clock host.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover these directed scenarios (latencies per REQ-014/REQ-020):
- Reset, then no latch, then 5 pulse rises -> snes_data = 1 throughout, bit_count = 0, frame_done never asserts.
- buttons = 12'h801 (B, R), latch 4 cycles, then 16 pulses of 2 high / 2 low -> serial stream sampled at pulse falls = 0,1,1,1,1,1,1,1,1,1,1,0,1,1,1,1 (first bit presented after latch fall); frame_done 1 cycle after the 16th rise; snes_data = 0 afterwards.
- Latch held high while buttons go 12'h000 -> 12'h400 -> after latch fall, snes_data = 1; after pulse 1, snes_data = 0 (Y).
- After 7 pulses, latch reasserts with buttons = 12'hFFF -> bit_count = 0; no frame_done; after the latch fall, the first 12 bits are 0 and the last 4 are 1.
- In DONE, 3 extra pulses -> snes_data stays 0, bit_count stays 16.
- Reset asserted after 9 pulses -> snes_data = 1, bit_count = 0; following pulses are ignored until the next latch.
